aes256_key_expander: RTL and testbench

On-the-fly AES-256 key schedule that produces one 128-bit round key per round, for rounds 0..14, in lock-step with the round counter's `advance` strobe. It sits beside the round counter and directly feeds the AddRoundKey stage of the round datapath. It holds a two-round sliding window of schedule words instead of a 15-entry key table. `rk_round` lets the controller cross-check alignment with the round counter's `round` output.

---
 rtl/aes256_key_expander_if.sv | 21 ++
 rtl/aes256_key_expander.sv | 160 ++++++++++++++++
 tb/tb_aes256_key_expander.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/aes256_key_expander_if.sv
// Control/key-stream bundle between the round controller and the AES-256
// on-the-fly key expander. The controller is the master and the expander is the slave.
interface aes256_key_expander_if;
  logic         key_load;
  logic [255:0] key_in;
  logic         advance;
  logic [127:0] round_key;
  logic [3:0]   rk_round;
  logic         rk_valid;
  logic         exhausted;

  modport master (
    output key_load, key_in, advance,
    input  round_key, rk_round, rk_valid, exhausted
  );

  modport slave (
    input  key_load, key_in, advance,
    output round_key, rk_round, rk_valid, exhausted
  );
endinterface

// File: rtl/aes256_key_expander.sv
// AES-256 on-the-fly key schedule: one 128-bit round key per advance, rounds 0..14.
// Optional macro KEY_REPLAY_EN: keep the cipher key and wrap to round 0 after round 14.

module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  // Forward AES S-box; element 0 is the leftmost byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_byte = SBOX[in_byte];
endmodule

module aes256_key_expander (
  input  logic                        clk,
  input  logic                        rst_n,
  aes256_key_expander_if.slave        kx
);
  localparam logic [3:0] LAST_ROUND     = 4'd14;
  localparam logic [3:0] LAST_NXT_ROUND = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_EXHAUSTED
  } state_t;

  state_t       state, state_nxt;
  logic [127:0] win_a;
  logic [127:0] win_b;
  logic [7:0]   rcon;
  logic [3:0]   rk_round;

  logic         do_load;
  logic         do_step;
`ifdef KEY_REPLAY_EN
  logic         do_wrap;
  logic [255:0] key_copy;
`endif

  // Next-window word generation from the last word of the window.
  logic         even_round;
  logic [31:0]  t_word;
  logic [31:0]  sub_in;
  logic [31:0]  sub_out;
  logic [31:0]  g_word;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] nxt;
  logic [7:0]   rcon_nxt;

  assign even_round = ~rk_round[0];
  assign t_word     = win_b[31:0];
  assign sub_in     = even_round ? {t_word[23:0], t_word[31:24]} : t_word;

  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (
      .in_byte  (sub_in[8*i +: 8]),
      .out_byte (sub_out[8*i +: 8])
    );
  end

  assign g_word   = sub_out ^ (even_round ? {rcon, 24'h0} : 32'h0);
  assign n0       = win_a[127:96] ^ g_word;
  assign n1       = win_a[95:64]  ^ n0;
  assign n2       = win_a[63:32]  ^ n1;
  assign n3       = win_a[31:0]   ^ n2;
  assign nxt      = {n0, n1, n2, n3};
  assign rcon_nxt = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    do_load   = 1'b0;
    do_step   = 1'b0;
`ifdef KEY_REPLAY_EN
    do_wrap   = 1'b0;
`endif
    if (kx.key_load) begin
      do_load   = 1'b1;
      state_nxt = ST_ACTIVE;
    end else if (kx.advance && (state == ST_ACTIVE)) begin
      if (rk_round == LAST_ROUND) begin
`ifdef KEY_REPLAY_EN
        do_wrap   = 1'b1;
`else
        state_nxt = ST_EXHAUSTED;
`endif
      end else begin
        do_step = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_a    <= '0;
      win_b    <= '0;
      rcon     <= 8'h01;
      rk_round <= '0;
`ifdef KEY_REPLAY_EN
      // NOTE: the key copy is a plain register bank, so it is reset along with the window.
      key_copy <= '0;
`endif
    end else if (do_load) begin
      win_a    <= kx.key_in[255:128];
      win_b    <= kx.key_in[127:0];
      rcon     <= 8'h01;
      rk_round <= '0;
`ifdef KEY_REPLAY_EN
      key_copy <= kx.key_in;
    end else if (do_wrap) begin
      win_a    <= key_copy[255:128];
      win_b    <= key_copy[127:0];
      rcon     <= 8'h01;
      rk_round <= '0;
`endif
    end else if (do_step) begin
      win_a    <= win_b;
      // Rounds 13 and 14 never need a further key, so win_b simply holds.
      if (rk_round <= LAST_NXT_ROUND) begin
        win_b <= nxt;
      end
      if (even_round) begin
        rcon <= rcon_nxt;
      end
      rk_round <= rk_round + 4'd1;
    end
  end

  assign kx.round_key = win_a;
  assign kx.rk_round  = rk_round;
  assign kx.rk_valid  = (state == ST_ACTIVE);
  assign kx.exhausted = (state == ST_EXHAUSTED);
endmodule

// File: tb/tb_aes256_key_expander.sv
// Scoreboard bench for aes256_key_expander using FIPS-197 A.3 and C.3 key schedules.
// Honors KEY_REPLAY_EN for the round-14 wrap behaviour.
module tb_aes256_key_expander;
  logic clk;
  logic rst_n;

  aes256_key_expander_if kx ();

  aes256_key_expander dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kx    (kx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [255:0] KEY_A3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  typedef struct {
    logic [127:0] key;
    bit           key_known;
    logic [3:0]   rnd;
    logic         valid;
    logic         exh;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [127:0] k, input bit kn, input int r,
                              input logic v, input logic e);
    exp_t x;
    x.key       = k;
    x.key_known = kn;
    x.rnd       = 4'(r);
    x.valid     = v;
    x.exh       = e;
    return x;
  endfunction

  // Valid round keys; unknown-key rounds still check index/valid/exhausted.
  function automatic exp_t a3(input int r);
    case (r)
      0:       return mk(128'h603deb1015ca71be2b73aef0857d7781, 1, r, 1'b1, 1'b0);
      1:       return mk(128'h1f352c073b6108d72d9810a30914dff4, 1, r, 1'b1, 1'b0);
      2:       return mk(128'h9ba354118e6925afa51a8b5f2067fcde, 1, r, 1'b1, 1'b0);
      3:       return mk(128'ha8b09c1a93d194cdbe49846eb75d5b9a, 1, r, 1'b1, 1'b0);
      default: return mk(128'h0, 0, r, 1'b1, 1'b0);
    endcase
  endfunction

  function automatic exp_t c3(input int r);
    case (r)
      0:       return mk(128'h000102030405060708090a0b0c0d0e0f, 1, r, 1'b1, 1'b0);
      1:       return mk(128'h101112131415161718191a1b1c1d1e1f, 1, r, 1'b1, 1'b0);
      2:       return mk(128'ha573c29fa176c498a97fce93a572c09c, 1, r, 1'b1, 1'b0);
      3:       return mk(128'h1651a8cd0244beda1a5da4c10640bade, 1, r, 1'b1, 1'b0);
      14:      return mk(128'h24fc79ccbf0979e9371ac23c6d68de36, 1, r, 1'b1, 1'b0);
      default: return mk(128'h0, 0, r, 1'b1, 1'b0);
    endcase
  endfunction

  // Called at a falling edge: drive for one cycle, release at the next falling edge.
  task automatic drive(input logic ld, input logic adv, input logic [255:0] key);
    kx.key_load = ld;
    kx.advance  = adv;
    kx.key_in   = key;
    @(negedge clk);
    kx.key_load = 1'b0;
    kx.advance  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: any change in the output tuple consumes one scoreboard entry.
  initial begin
    logic [127:0] last_key;
    logic [3:0]   last_rnd;
    logic         last_v, last_e;
    bit           have_last;
    exp_t         e;
    have_last = 0;
    forever begin
      @(negedge clk);
      if (!have_last || kx.round_key !== last_key || kx.rk_round !== last_rnd ||
          kx.rk_valid !== last_v || kx.exhausted !== last_e) begin
        have_last = 1;
        last_key  = kx.round_key;
        last_rnd  = kx.rk_round;
        last_v    = kx.rk_valid;
        last_e    = kx.exhausted;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got key=%h round=%0d valid=%b exhausted=%b, want no change",
                   kx.round_key, kx.rk_round, kx.rk_valid, kx.exhausted);
        end else begin
          e = sb.pop_front();
          if (e.key_known) check("round_key", kx.round_key, e.key);
          check("rk_round",  128'(kx.rk_round),  128'(e.rnd));
          check("rk_valid",  128'(kx.rk_valid),  128'(e.valid));
          check("exhausted", 128'(kx.exhausted), 128'(e.exh));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b1;
    kx.key_load = 1'b0;
    kx.advance  = 1'b0;
    kx.key_in   = '0;
    sb.push_back(mk(128'h0, 1, 0, 1'b0, 1'b0));
    #2 rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;

    // Idle advances before any key are ignored.
    repeat (3) drive(1'b0, 1'b1, '0);

    sb.push_back(a3(0));
    drive(1'b1, 1'b0, KEY_A3);
    for (int r = 1; r <= 3; r++) begin
      sb.push_back(a3(r));
      drive(1'b0, 1'b1, '0);
    end

    // Restart mid-schedule with the C.3 key, then walk to round 14 with gaps.
    sb.push_back(c3(0));
    drive(1'b1, 1'b0, KEY_C3);
    for (int r = 1; r <= 14; r++) begin
      idle(r % 4);
      sb.push_back(c3(r));
      drive(1'b0, 1'b1, '0);
    end

`ifdef KEY_REPLAY_EN
    sb.push_back(c3(0));
    drive(1'b0, 1'b1, '0);
    sb.push_back(c3(1));
    drive(1'b0, 1'b1, '0);
`else
    sb.push_back(mk(128'h24fc79ccbf0979e9371ac23c6d68de36, 1, 14, 1'b0, 1'b1));
    drive(1'b0, 1'b1, '0);
    idle(1);
    drive(1'b0, 1'b1, '0);
`endif

    // Load wins over advance in the same cycle at round 7.
    sb.push_back(a3(0));
    drive(1'b1, 1'b0, KEY_A3);
    for (int r = 1; r <= 7; r++) begin
      sb.push_back(a3(r));
      drive(1'b0, 1'b1, '0);
    end
    sb.push_back(c3(0));
    drive(1'b1, 1'b1, KEY_C3);
    for (int r = 1; r <= 5; r++) begin
      sb.push_back(c3(r));
      drive(1'b0, 1'b1, '0);
    end

    // Asynchronous reset in the middle of a cycle at round 5.
    @(posedge clk);
    #2;
    sb.push_back(mk(128'h0, 1, 0, 1'b0, 1'b0));
    rst_n = 1'b0;
    #1;
    check("async_rst_round_key", kx.round_key, 128'h0);
    check("async_rst_rk_round",  128'(kx.rk_round), 128'h0);
    check("async_rst_rk_valid",  128'(kx.rk_valid), 128'h0);
    @(negedge clk);
    idle(1);
    rst_n = 1'b1;
    repeat (2) drive(1'b0, 1'b1, '0);

    idle(4);
    check("scoreboard_drained", 128'(sb.size()), 128'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
